data_mem_responder: RTL
=======================

# data_mem_responder

Multi-cycle data-memory responder for the single-cycle MIPS core. It accepts the core's load/store requests (`MemRead`, `MemWrite`, `address`, `write_data_ram`) and services each one from an internal word-addressed RAM after a programmable number of wait states. While a request is in progress it drives `mem_pause` to freeze the core's PC. It replaces the zero-wait-state data memory, and its `mem_pause` feeds the core's `pause` input.

## Interface
- `DEPTH`, 256: number of 32-bit words in the RAM; power of two, 4..4096.
- `LATENCY`, 3: total stall cycles per access; legal range 1..15.
- `CLOCK_50`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request from the control unit.
- `MemWrite`  in  1  store request from the control unit.
- `address`  in  32  byte address from the ALU result.
- `write_data_ram`  in  32  store data.
- `read_data`  out  32  load data; registered.
- `mem_pause`  out  1  stall request to the core.
- `mem_error`  out  1  high for the DONE cycle of a rejected access.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - Request = `MemRead | MemWrite`.
  - On a request: latch `address`, `write_data_ram` and op (write if `MemWrite`, otherwise read).
  - Next state is BUSY with count = `LATENCY`-2 when `LATENCY` ≥ 2; next state is DONE when `LATENCY` = 1.
  - With no request, stay in IDLE.
- **BUSY**
  - Request inputs are ignored.
  - Count decrements each cycle.
  - At count = 0, perform the access on the latched values and go to DONE.
- **DONE**
  - `mem_pause` is 0 for this one cycle, so the core retires the instruction on this edge.
  - `read_data` is valid for the whole cycle.
  - Request inputs are ignored.
  - Next state is always IDLE.
- **Access (on the transition into DONE)**
  - Word index = `address[31:2]`.
  - Valid access: `address[1:0]` = 0 and index < `DEPTH`.
  - Valid write: RAM[index] ← data; `read_data` ← 0.
  - Valid read: `read_data` ← RAM[index].
  - Invalid access (misaligned or out of range): RAM is unchanged, `read_data` ← 0, and `mem_error` is 1 during DONE.
- **Simultaneous `MemRead` and `MemWrite`**: treated as a write. `read_data` ← 0 and `mem_error` stays 0.
- **`mem_pause`** = !`reset` & ((IDLE & request) | BUSY). It is combinational from the request in IDLE, so the first stall covers the request cycle itself.
- **`mem_error`** = DONE & latched-invalid flag.
- **`read_data`** holds its value outside DONE and is overwritten only on entry to DONE.
- **Reset**
  - Clears state to IDLE, `read_data` to 0, the count and the latched flag.
  - RAM contents are not cleared.
  - Reset in BUSY abandons the access: a pending write is discarded and no DONE cycle occurs.
  - `mem_pause` is 0 in every cycle where `reset` is high.

## Timing
- Reset values: `read_data` = 0, `mem_pause` = 0, `mem_error` = 0, state = IDLE.
- A request first presented in cycle t:
  - `mem_pause` is high in cycles t .. t+`LATENCY`-1.
  - DONE is in cycle t+`LATENCY`, with `read_data` valid.
  - IDLE is in cycle t+`LATENCY`+1, where the next instruction's request is sampled.
- Throughput: one access per `LATENCY`+1 cycles. Back-to-back loads/stores therefore always have one non-paused cycle between them.
- The core holds its request inputs stable while `mem_pause` = 1. The responder does not depend on this after the IDLE latch.
- Non-memory instructions cause no stall and no state change.

## Test plan
- **Reset, then idle**: after `reset`, `read_data` = 0 and `mem_pause` = 0. With no requests for 10 cycles, `mem_pause` stays 0.
- **Store then load, `LATENCY` = 3**:
  - Store 0xDEADBEEF to 0x10: `mem_pause` is high for 3 cycles, then DONE.
  - Load from 0x10 in the next IDLE cycle: `mem_pause` is high for 3 cycles, and `read_data` = 0xDEADBEEF in DONE (cycle t+3).
- **`LATENCY` = 1**: a load from 0x0 after storing 0x12345678 gives one stall cycle, then `read_data` = 0x12345678 on the next cycle.
- **Error cases**:
  - Misaligned load at 0x13: `mem_error` = 1 in DONE and `read_data` = 0.
  - Store to 0x400 with `DEPTH` = 256 gives `mem_error` = 1, and a following load from 0x0 returns its prior contents unchanged.
- **Reset mid-operation**: store 0xAAAA5555 to 0x20 and assert `reset` in the second BUSY cycle. `mem_pause` drops to 0 that cycle and no DONE occurs. A later load from 0x20 returns the old value.
- **Back-to-back requests**: hold `MemRead` high continuously with a changing `address`. The bench sees exactly one access per `LATENCY`+1 cycles, and each DONE returns the word for the address latched in its IDLE cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: services MIPS load/store requests from an internal
// word RAM after LATENCY stall cycles, driving mem_pause to freeze the core meanwhile.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 3
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data_ram,
    output logic [31:0] read_data,
    output logic        mem_pause,
    output logic        mem_error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam bit          SINGLE   = (LATENCY == 1);
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]  state, state_next;
    logic [3:0]  count, count_next;
    logic [31:0] addr_q, data_q;
    logic        wr_q;
    logic        err_q;

    logic        request;
    logic [31:0] acc_addr, acc_data;
    logic        acc_wr;
    logic        acc_valid;
    logic [AW-1:0] acc_idx;
    logic        do_access;

    logic [31:0] mem [DEPTH];

    assign request = MemRead | MemWrite;

    // With LATENCY = 1 the access happens on the IDLE edge, so it must use the live inputs.
    always_comb begin
        if (state == IDLE) begin
            acc_addr = address;
            acc_data = write_data_ram;
            acc_wr   = MemWrite;
        end else begin
            acc_addr = addr_q;
            acc_data = data_q;
            acc_wr   = wr_q;
        end
    end

    assign acc_idx   = acc_addr[AW+1:2];
    assign acc_valid = (acc_addr[1:0] == 2'b00) && (acc_addr[31:AW+2] == '0);
    assign do_access = !reset && (((state == IDLE) && request && SINGLE) ||
                                  ((state == BUSY) && (count == 4'd0)));

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (request) begin
                    if (SINGLE) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        count_next = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (count == 4'd0) begin
                    state_next = DONE;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            err_q     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (do_access) begin
                err_q     <= !acc_valid;
                read_data <= (acc_valid && !acc_wr) ? mem[acc_idx] : 32'd0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset && (state == IDLE) && request) begin
            addr_q <= address;
            data_q <= write_data_ram;
            wr_q   <= MemWrite;
        end
    end

    // RAM is deliberately not reset; do_access already excludes reset cycles.
    always_ff @(posedge CLOCK_50) begin
        if (do_access && acc_wr && acc_valid) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign mem_pause = !reset && (((state == IDLE) && request) || (state == BUSY));
    assign mem_error = (state == DONE) && err_q;

endmodule
